regu_intl_sched: RTL and testbench



---
 rtl/regu_intl_sched_pkg.sv | 26 ++
 rtl/regu_intl_sched_if.sv | 26 ++
 rtl/regu_intl_sched_ch_ctrl.sv | 96 +++++++++
 rtl/regu_intl_sched.sv | 155 +++++++++++++++
 tb/tb_regu_intl_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/regu_intl_sched_pkg.sv
// Shared encodings and constants for the regulation interlock scheduler.
package regu_intl_sched_pkg;

    localparam int FP_W        = 32;
    localparam int TMO_CYC_DEF = 64;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_DELAY = 2'd1,
        C_PEND  = 2'd2,
        C_WAIT  = 2'd3
    } ch_state_e;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ISSUE = 2'd1,
        A_WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [FP_W-1:0] diff;
    } cmp_op_t;

endpackage

// File: rtl/regu_intl_sched_if.sv
// Issue/result link between the scheduler and the shared FP compare pipeline.
interface regu_intl_sched_if #(
    parameter int TAG_W = 3
);
    import regu_intl_sched_pkg::*;

    logic             cmp_valid;
    logic [FP_W-1:0]  cmp_a;
    logic [FP_W-1:0]  cmp_b;
    logic [FP_W-1:0]  cmp_diff;
    logic [TAG_W-1:0] cmp_tag;
    logic             res_valid;
    logic             res_flag;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output cmp_valid, cmp_a, cmp_b, cmp_diff, cmp_tag,
        input  res_valid, res_flag, res_tag
    );

    modport slave (
        input  cmp_valid, cmp_a, cmp_b, cmp_diff, cmp_tag,
        output res_valid, res_flag, res_tag
    );

endinterface

// File: rtl/regu_intl_sched_ch_ctrl.sv
// Per-channel controller: set-point change detect, settle delay, request state
// and the sticky regulation-fault flag.
module regu_ch_ctrl
    import regu_intl_sched_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            en,
    input  logic            clr,
    input  logic [FP_W-1:0] set_point,
    input  logic [FP_W-1:0] delay,
    input  logic            grant,
    input  logic            res_ok,
    input  logic            res_flag,
    input  logic            retry,
    output logic            req,
    output logic            flag,
    output ch_state_e       state
);

    ch_state_e       state_nxt;
    logic [FP_W-1:0] sp_buf;
    logic [FP_W-1:0] cnt, cnt_nxt;
    logic            rearm, rearm_nxt;
    logic            flag_nxt;
    logic            change;

    assign change = (sp_buf != set_point);
    assign req    = en && (state == C_PEND);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rearm_nxt = rearm;
        if (!en) begin
            state_nxt = C_IDLE;
            cnt_nxt   = '0;
            rearm_nxt = 1'b0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (change && !flag) begin
                        state_nxt = C_DELAY;
                        cnt_nxt   = '0;
                    end
                end
                C_DELAY: begin
                    if (change)            cnt_nxt   = '0;
                    else if (cnt >= delay) state_nxt = C_PEND;
                    else                   cnt_nxt   = cnt + 32'd1;
                end
                C_PEND: begin
                    if (change) rearm_nxt = 1'b1;
                    if (grant)  state_nxt = C_WAIT;
                end
                C_WAIT: begin
                    if (change) rearm_nxt = 1'b1;
                    if (res_ok) begin
                        // A set point that moved while the compare was in flight needs a fresh settle.
                        state_nxt = (rearm || change) ? C_DELAY : C_IDLE;
                        cnt_nxt   = '0;
                        rearm_nxt = 1'b0;
                    end else if (retry) begin
                        state_nxt = C_PEND;
                    end
                end
                default: state_nxt = C_IDLE;
            endcase
        end
    end

    always_comb begin
        flag_nxt = flag;
        if (en && (state == C_WAIT) && res_ok && res_flag) flag_nxt = 1'b1;
        else if (clr)                                      flag_nxt = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= C_IDLE;
            sp_buf <= '0;
            cnt    <= '0;
            rearm  <= 1'b0;
            flag   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sp_buf <= set_point;
            cnt    <= cnt_nxt;
            rearm  <= rearm_nxt;
            flag   <= flag_nxt;
        end
    end

endmodule

// File: rtl/regu_intl_sched.sv
// Round-robin scheduler granting the shared FP compare pipeline to CH_NUM
// regulated channels, with result timeout and tag checking.
module regu_intl_sched
    import regu_intl_sched_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int TAG_W   = 3,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CH_NUM-1:0]      i_regu_en,
    input  logic [CH_NUM-1:0]      i_clr,
    input  logic                   i_err_clr,
    input  logic [FP_W*CH_NUM-1:0] i_set_point,
    input  logic [FP_W*CH_NUM-1:0] i_data,
    input  logic [FP_W*CH_NUM-1:0] i_diff,
    input  logic [FP_W*CH_NUM-1:0] i_delay,
    regu_intl_sched_if.master      pipe,
    output logic [CH_NUM-1:0]      o_regu_flag,
    output logic                   o_pipe_err,
    output logic                   o_busy,
    output logic [2*CH_NUM-1:0]    o_ch_state
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    arb_state_e       arb_state, arb_nxt;
    logic [CH_NUM-1:0] req, grant_oh, res_ok_oh, retry_oh;
    logic [TAG_W-1:0] gnt, rr_ptr, pick, pick_lo, pick_hi;
    logic             any_lo, any_hi, pick_any;
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_set;
    cmp_op_t          cmp_q, cmp_d;
    ch_state_e        ch_st [CH_NUM];

    function automatic logic [CH_NUM-1:0] dec(input logic [TAG_W-1:0] idx);
        logic [CH_NUM-1:0] oh;
        oh = '0;
        for (int k = 0; k < CH_NUM; k++) oh[k] = (idx == TAG_W'(k));
        return oh;
    endfunction

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        regu_ch_ctrl u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .en        (i_regu_en[k]),
            .clr       (i_clr[k]),
            .set_point (i_set_point[FP_W*k +: FP_W]),
            .delay     (i_delay[FP_W*k +: FP_W]),
            .grant     (grant_oh[k]),
            .res_ok    (res_ok_oh[k]),
            .res_flag  (pipe.res_flag),
            .retry     (retry_oh[k]),
            .req       (req[k]),
            .flag      (o_regu_flag[k]),
            .state     (ch_st[k])
        );
        assign o_ch_state[2*k +: 2] = ch_st[k];
    end

    // Lowest requester at or above rr_ptr, else lowest requester overall.
    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        any_lo  = 1'b0;
        any_hi  = 1'b0;
        cmp_d   = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick_lo = TAG_W'(k);
                any_lo  = 1'b1;
                if (TAG_W'(k) >= rr_ptr) begin
                    pick_hi = TAG_W'(k);
                    any_hi  = 1'b1;
                end
            end
        end
        pick     = any_hi ? pick_hi : pick_lo;
        pick_any = any_lo;
        for (int k = 0; k < CH_NUM; k++) begin
            if (pick == TAG_W'(k)) begin
                cmp_d.a    = i_set_point[FP_W*k +: FP_W];
                cmp_d.b    = i_data[FP_W*k +: FP_W];
                cmp_d.diff = i_diff[FP_W*k +: FP_W];
            end
        end
    end

    always_comb begin
        arb_nxt   = arb_state;
        grant_oh  = '0;
        res_ok_oh = '0;
        retry_oh  = '0;
        err_set   = 1'b0;
        case (arb_state)
            A_IDLE: begin
                err_set = pipe.res_valid;
                if (pick_any) begin
                    grant_oh = dec(pick);
                    arb_nxt  = A_ISSUE;
                end
            end
            A_ISSUE: begin
                err_set = pipe.res_valid;
                arb_nxt = A_WAIT;
            end
            A_WAIT: begin
                if (pipe.res_valid && (pipe.res_tag == gnt)) begin
                    res_ok_oh = dec(gnt);
                    arb_nxt   = A_IDLE;
                end else if (pipe.res_valid || (tmo_cnt == TMO_W'(TMO_CYC - 1))) begin
                    err_set  = 1'b1;
                    retry_oh = dec(gnt);
                    arb_nxt  = A_IDLE;
                end
            end
            default: arb_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) arb_state <= A_IDLE;
        else       arb_state <= arb_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt        <= '0;
            rr_ptr     <= '0;
            cmp_q      <= '0;
            tmo_cnt    <= '0;
            o_pipe_err <= 1'b0;
        end else begin
            if ((arb_state == A_IDLE) && pick_any) begin
                gnt   <= pick;
                cmp_q <= cmp_d;
            end
            if (arb_state == A_ISSUE)
                rr_ptr <= (gnt == TAG_W'(CH_NUM - 1)) ? '0 : gnt + TAG_W'(1);
            tmo_cnt <= (arb_state == A_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if (err_set)        o_pipe_err <= 1'b1;
            else if (i_err_clr) o_pipe_err <= 1'b0;
        end
    end

    assign pipe.cmp_valid = (arb_state == A_ISSUE);
    assign pipe.cmp_a     = cmp_q.a;
    assign pipe.cmp_b     = cmp_q.b;
    assign pipe.cmp_diff  = cmp_q.diff;
    assign pipe.cmp_tag   = gnt;
    assign o_busy         = (arb_state != A_IDLE);

endmodule

// File: tb/tb_regu_intl_sched.sv
// Directed self-checking bench for regu_intl_sched (CH_NUM=4, TMO_CYC=64).
module tb_regu_intl_sched;
    import regu_intl_sched_pkg::*;

    localparam int CH_NUM  = 4;
    localparam int TAG_W   = 3;
    localparam int TMO_CYC = 64;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [CH_NUM-1:0]      regu_en, clr;
    logic                   err_clr;
    logic [FP_W*CH_NUM-1:0] sp, data, diff, dly;
    logic [CH_NUM-1:0]      regu_flag;
    logic                   pipe_err, busy;
    logic [2*CH_NUM-1:0]    ch_state;

    int n_checks = 0;
    int n_errors = 0;

    regu_intl_sched_if #(.TAG_W(TAG_W)) pipe ();

    regu_intl_sched #(.CH_NUM(CH_NUM), .TAG_W(TAG_W), .TMO_CYC(TMO_CYC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_regu_en   (regu_en),
        .i_clr       (clr),
        .i_err_clr   (err_clr),
        .i_set_point (sp),
        .i_data      (data),
        .i_diff      (diff),
        .i_delay     (dly),
        .pipe        (pipe),
        .o_regu_flag (regu_flag),
        .o_pipe_err  (pipe_err),
        .o_busy      (busy),
        .o_ch_state  (ch_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] df, input int dl);
        sp[32*k +: 32]   = s;
        data[32*k +: 32] = d;
        diff[32*k +: 32] = df;
        dly[32*k +: 32]  = 32'(dl);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_valid"}, pipe.cmp_valid, 0);
        check({name, "_a"},     pipe.cmp_a, 0);
        check({name, "_tag"},   pipe.cmp_tag, 0);
        check({name, "_flag"},  regu_flag, 0);
        check({name, "_err"},   pipe_err, 0);
        check({name, "_busy"},  busy, 0);
        check({name, "_state"}, ch_state, 0);
    endtask

    // Waits (bounded) for the issue strobe; latency counted in negedges.
    task automatic expect_issue(input string name, input int exp_lat, input int exp_tag,
                                input logic [31:0] exp_a);
        int cyc;
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (!pipe.cmp_valid && cyc < 200);
        check({name, "_lat"}, cyc, exp_lat);
        check({name, "_tag"}, pipe.cmp_tag, exp_tag);
        check({name, "_a"},   pipe.cmp_a, exp_a);
    endtask

    task automatic finish_txn(input int tag, input logic flag);
        @(negedge i_clk);
        check("strobe_1cyc", pipe.cmp_valid, 0);
        pipe.res_valid = 1'b1;
        pipe.res_tag   = TAG_W'(tag);
        pipe.res_flag  = flag;
        @(negedge i_clk);
        pipe.res_valid = 1'b0;
        pipe.res_flag  = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge i_clk);
        err_clr = 1'b0;
        check("err_clr", pipe_err, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int cnt;
        i_rst = 1'b1;
        regu_en = '1; clr = '0; err_clr = 1'b0;
        sp = '0; data = '0; diff = '0; dly = '0;
        pipe.res_valid = 1'b0; pipe.res_flag = 1'b0; pipe.res_tag = '0;
        repeat (2) @(negedge i_clk);
        check_quiet("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Single channel: 0 -> 10.0, delay 5, result within tolerance.
        set_ch(0, 32'h41200000, 32'h411F3333, 32'h3DCCCCCD, 5);
        expect_issue("t1", 8, 0, 32'h41200000);
        check("t1_b", pipe.cmp_b, 32'h411F3333);
        check("t1_diff", pipe.cmp_diff, 32'h3DCCCCCD);
        check("t1_st_wait", ch_state[1:0], C_WAIT);
        finish_txn(0, 1'b0);
        check("t1_flag0", regu_flag[0], 0);
        check("t1_idle", ch_state[1:0], C_IDLE);
        cnt = 0;
        repeat (10) begin @(negedge i_clk); cnt += int'(pipe.cmp_valid); end
        check("t1_once", cnt, 0);

        // Same channel, deviation exceeds: sticky flag until clear.
        set_ch(0, 32'h41400000, 32'h411F3333, 32'h3DCCCCCD, 5);
        expect_issue("t1b", 8, 0, 32'h41400000);
        check("t1b_flag_pre", regu_flag[0], 0);
        finish_txn(0, 1'b1);
        check("t1b_flag_set", regu_flag[0], 1);
        repeat (5) @(negedge i_clk);
        check("t1b_flag_hold", regu_flag[0], 1);
        clr[0] = 1'b1;
        @(negedge i_clk);
        clr[0] = 1'b0;
        check("t1b_flag_clr", regu_flag[0], 0);

        // Reset pulsed while the arbiter waits for a result.
        set_ch(0, 32'h40E00000, 32'h411F3333, 32'h3DCCCCCD, 5);
        expect_issue("rst", 8, 0, 32'h40E00000);
        @(negedge i_clk);
        check("rst_busy", busy, 1);
        i_rst = 1'b1;
        regu_en = '0;
        #1;
        check_quiet("rst_during");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_quiet("rst_after");

        // Burst: all channels change together, served 0,1,2,3 twice.
        regu_en = '1;
        for (int k = 0; k < CH_NUM; k++) set_ch(k, 32'h3F800000 + 32'(k) * 32'h00800000, '0, '0, 2);
        for (int k = 0; k < CH_NUM; k++) begin
            expect_issue("burst1", (k == 0) ? 5 : 1, k, 32'h3F800000 + 32'(k) * 32'h00800000);
            finish_txn(k, 1'b0);
        end
        for (int k = 0; k < CH_NUM; k++) set_ch(k, 32'h40A00000 + 32'(k) * 32'h00400000, '0, '0, 2);
        for (int k = 0; k < CH_NUM; k++) begin
            expect_issue("burst2", (k == 0) ? 5 : 1, k, 32'h40A00000 + 32'(k) * 32'h00400000);
            finish_txn(k, 1'b0);
        end

        // Delay restart at cnt=3, then a change while the compare is in flight.
        set_ch(1, 32'h41300000, '0, '0, 5);
        repeat (4) @(negedge i_clk);
        check("restart_st", ch_state[3:2], C_DELAY);
        sp[63:32] = 32'h41500000;
        expect_issue("restart", 8, 1, 32'h41500000);
        sp[63:32] = 32'h41580000;
        finish_txn(1, 1'b0);
        expect_issue("rearm", 7, 1, 32'h41580000);
        finish_txn(1, 1'b0);

        // Pipeline never answers: timeout, error, reissue.
        set_ch(2, 32'h42000000, '0, '0, 0);
        expect_issue("tmo", 3, 2, 32'h42000000);
        cnt = 0;
        do begin @(negedge i_clk); cnt++; end while (!pipe_err && cnt < 100);
        check("tmo_lat", cnt, TMO_CYC + 1);
        expect_issue("tmo_retry", 1, 2, 32'h42000000);
        finish_txn(2, 1'b0);
        clear_err();

        // Wrong tag: error and reissue.
        set_ch(3, 32'h42100000, '0, '0, 0);
        expect_issue("wtag", 3, 3, 32'h42100000);
        finish_txn(1, 1'b0);
        check("wtag_err", pipe_err, 1);
        expect_issue("wtag_retry", 1, 3, 32'h42100000);
        finish_txn(3, 1'b0);
        clear_err();

        // Fault set and clear on the same cycle: set wins.
        set_ch(1, 32'h41100000, '0, '0, 5);
        expect_issue("setclr", 8, 1, 32'h41100000);
        clr[1] = 1'b1;
        finish_txn(1, 1'b1);
        clr[1] = 1'b0;
        check("setclr_flag", regu_flag[1], 1);
        clr[1] = 1'b1;
        @(negedge i_clk);
        clr[1] = 1'b0;
        check("setclr_cleared", regu_flag[1], 0);

        // Enable dropped while waiting: result discarded.
        set_ch(2, 32'h42200000, '0, '0, 0);
        expect_issue("endrop", 3, 2, 32'h42200000);
        regu_en[2] = 1'b0;
        finish_txn(2, 1'b1);
        check("endrop_flag", regu_flag[2], 0);
        check("endrop_err", pipe_err, 0);
        check("endrop_busy", busy, 0);
        check("endrop_st", ch_state[5:4], C_IDLE);
        regu_en[2] = 1'b1;
        repeat (3) @(negedge i_clk);
        check("endrop_quiet", ch_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
